// File: rtl/alu_issue_sched.sv
// ALU issue queue scheduler: collapsing age-ordered buffer with wakeup tracking,
// oldest-ready selection for the ALU lanes and same-cycle compaction plus append.
module alu_issue_sched #(
  parameter int QUEUE_LEN = 8,
  parameter int WRITE_NUM = 2,
  parameter int ISSUE_NUM = 2,
  parameter int WAKE_NUM  = 4,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [WRITE_NUM-1:0]           wr_valid,
  input  logic [WRITE_NUM*PREG_W-1:0]    wr_dst,
  input  logic [WRITE_NUM*PREG_W-1:0]    wr_src1_id,
  input  logic [WRITE_NUM*PREG_W-1:0]    wr_src2_id,
  input  logic [WRITE_NUM-1:0]           wr_src1_rdy,
  input  logic [WRITE_NUM-1:0]           wr_src2_rdy,
  input  logic [WRITE_NUM*PAYLOAD_W-1:0] wr_payload,
  output logic                           wr_ready,
  input  logic [WAKE_NUM-1:0]            wake_valid,
  input  logic [WAKE_NUM*PREG_W-1:0]     wake_id,
  input  logic [ISSUE_NUM-1:0]           fu_ready,
  output logic [ISSUE_NUM-1:0]           iss_valid,
  output logic [ISSUE_NUM*PREG_W-1:0]    iss_dst,
  output logic [ISSUE_NUM*PAYLOAD_W-1:0] iss_payload,
  output logic [$clog2(QUEUE_LEN):0]     count
);

  localparam int CNT_W = $clog2(QUEUE_LEN) + 1;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    dst;
    logic [PREG_W-1:0]    s1_id;
    logic                 s1_rdy;
    logic [PREG_W-1:0]    s2_id;
    logic                 s2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           entry_reg  [QUEUE_LEN];
  entry_t           entry_next [QUEUE_LEN];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [QUEUE_LEN-1:0] ent_ready;
  logic [QUEUE_LEN-1:0] issue_sel;
  logic [CNT_W-1:0]     ready_rank   [QUEUE_LEN];
  logic [CNT_W-1:0]     issued_below [QUEUE_LEN];
  logic [CNT_W-1:0]     lane_rank    [ISSUE_NUM];
  logic [CNT_W-1:0]     fu_cnt;
  logic [CNT_W-1:0]     ready_cnt;
  logic [CNT_W-1:0]     issued_cnt;
  logic [WRITE_NUM-1:0] wr_acc;
  logic [CNT_W-1:0]     wr_pos [WRITE_NUM];
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     surv_cnt;

  // Tag 0 is the hard-wired always-available register.
  function automatic logic tag_woken(input logic [PREG_W-1:0]          tag,
                                     input logic [WAKE_NUM-1:0]        wv,
                                     input logic [WAKE_NUM*PREG_W-1:0] wid);
    logic hit;
    hit = (tag == '0);
    for (int w = 0; w < WAKE_NUM; w++) begin
      if (wv[w] && (wid[w*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  for (genvar gi = 0; gi < QUEUE_LEN; gi++) begin : g_ready
    assign ent_ready[gi] = entry_reg[gi].valid & entry_reg[gi].s1_rdy & entry_reg[gi].s2_rdy;
  end

  assign count    = count_reg;
  assign wr_ready = ((CNT_W'(QUEUE_LEN) - count_reg) >= CNT_W'(WRITE_NUM));

  // Lane k serves the ready entry whose age rank equals the number of enabled lanes below k.
  always_comb begin
    fu_cnt = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      lane_rank[k] = fu_cnt;
      if (fu_ready[k]) fu_cnt = fu_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ready_cnt  = '0;
    issued_cnt = '0;
    issue_sel  = '0;
    for (int i = 0; i < QUEUE_LEN; i++) begin
      ready_rank[i]   = ready_cnt;
      issued_below[i] = issued_cnt;
      issue_sel[i]    = ent_ready[i] && (ready_cnt < fu_cnt);
      if (ent_ready[i]) ready_cnt = ready_cnt + CNT_W'(1);
      if (issue_sel[i]) issued_cnt = issued_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : g_lane
    logic                 sel_valid;
    logic [PREG_W-1:0]    sel_dst;
    logic [PAYLOAD_W-1:0] sel_payload;

    always_comb begin
      sel_valid   = 1'b0;
      sel_dst     = '0;
      sel_payload = '0;
      if (fu_ready[gi]) begin
        for (int i = 0; i < QUEUE_LEN; i++) begin
          if (ent_ready[i] && (ready_rank[i] == lane_rank[gi])) begin
            sel_valid   = 1'b1;
            sel_dst     = entry_reg[i].dst;
            sel_payload = entry_reg[i].payload;
          end
        end
      end
    end

    assign iss_valid[gi]                           = sel_valid;
    assign iss_dst[gi*PREG_W +: PREG_W]            = sel_dst;
    assign iss_payload[gi*PAYLOAD_W +: PAYLOAD_W]  = sel_payload;
  end

  // New entries append behind the survivors of this cycle's issue.
  always_comb begin
    wr_acc   = wr_ready ? wr_valid : '0;
    surv_cnt = count_reg - issued_cnt;
    wr_cnt   = '0;
    for (int k = 0; k < WRITE_NUM; k++) begin
      wr_pos[k] = surv_cnt + wr_cnt;
      if (wr_acc[k]) wr_cnt = wr_cnt + CNT_W'(1);
    end
    count_next = surv_cnt + wr_cnt;
  end

  always_comb begin
    entry_t e;
    e = '0;
    for (int j = 0; j < QUEUE_LEN; j++) begin
      entry_next[j] = '0;
      for (int i = 0; i < QUEUE_LEN; i++) begin
        if (entry_reg[i].valid && !issue_sel[i] &&
            ((CNT_W'(i) - issued_below[i]) == CNT_W'(j))) begin
          e        = entry_reg[i];
          e.s1_rdy = e.s1_rdy | tag_woken(e.s1_id, wake_valid, wake_id);
          e.s2_rdy = e.s2_rdy | tag_woken(e.s2_id, wake_valid, wake_id);
          entry_next[j] = e;
        end
      end
      for (int k = 0; k < WRITE_NUM; k++) begin
        if (wr_acc[k] && (wr_pos[k] == CNT_W'(j))) begin
          e.valid   = 1'b1;
          e.dst     = wr_dst[k*PREG_W +: PREG_W];
          e.s1_id   = wr_src1_id[k*PREG_W +: PREG_W];
          e.s2_id   = wr_src2_id[k*PREG_W +: PREG_W];
          e.s1_rdy  = wr_src1_rdy[k] | tag_woken(e.s1_id, wake_valid, wake_id);
          e.s2_rdy  = wr_src2_rdy[k] | tag_woken(e.s2_id, wake_valid, wake_id);
          e.payload = wr_payload[k*PAYLOAD_W +: PAYLOAD_W];
          entry_next[j] = e;
        end
      end
    end
  end

  // Payload and tags need no reset; only valid bits and the count define occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_reg <= '0;
      for (int i = 0; i < QUEUE_LEN; i++) begin
        entry_reg[i].valid <= 1'b0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < QUEUE_LEN; i++) begin
        entry_reg[i] <= entry_next[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized and directed bench for alu_issue_sched against a queue-based reference model.
module tb_alu_issue_sched;

  localparam int QL = 8;
  localparam int WN = 2;
  localparam int IN = 2;
  localparam int KN = 4;
  localparam int PW = 6;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [WN-1:0]     wr_valid;
  logic [WN*PW-1:0]  wr_dst;
  logic [WN*PW-1:0]  wr_src1_id;
  logic [WN*PW-1:0]  wr_src2_id;
  logic [WN-1:0]     wr_src1_rdy;
  logic [WN-1:0]     wr_src2_rdy;
  logic [WN*DW-1:0]  wr_payload;
  logic              wr_ready;
  logic [KN-1:0]     wake_valid;
  logic [KN*PW-1:0]  wake_id;
  logic [IN-1:0]     fu_ready;
  logic [IN-1:0]     iss_valid;
  logic [IN*PW-1:0]  iss_dst;
  logic [IN*DW-1:0]  iss_payload;
  logic [3:0]        count;

  always #5 clk = ~clk;

  alu_issue_sched #(
    .QUEUE_LEN(QL), .WRITE_NUM(WN), .ISSUE_NUM(IN),
    .WAKE_NUM(KN), .PREG_W(PW), .PAYLOAD_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_dst(wr_dst),
    .wr_src1_id(wr_src1_id), .wr_src2_id(wr_src2_id),
    .wr_src1_rdy(wr_src1_rdy), .wr_src2_rdy(wr_src2_rdy),
    .wr_payload(wr_payload), .wr_ready(wr_ready),
    .wake_valid(wake_valid), .wake_id(wake_id),
    .fu_ready(fu_ready), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_payload(iss_payload), .count(count)
  );

  typedef struct {
    logic [PW-1:0] dst;
    logic [PW-1:0] s1;
    logic [PW-1:0] s2;
    logic          r1;
    logic          r2;
    logic [DW-1:0] pl;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit woken(input logic [PW-1:0] t);
    if (t == '0) return 1'b1;
    for (int w = 0; w < KN; w++)
      if (wake_valid[w] && (wake_id[w*PW +: PW] == t)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle(input logic [IN-1:0] fu);
    reset       = 1'b0;
    flush       = 1'b0;
    wr_valid    = '0;
    wr_dst      = '0;
    wr_src1_id  = '0;
    wr_src2_id  = '0;
    wr_src1_rdy = '0;
    wr_src2_rdy = '0;
    wr_payload  = '0;
    wake_valid  = '0;
    wake_id     = '0;
    fu_ready    = fu;
  endtask

  task automatic set_wr(input int k, input logic [PW-1:0] d, input logic [PW-1:0] s1,
                        input logic r1, input logic [PW-1:0] s2, input logic r2);
    wr_valid[k]              = 1'b1;
    wr_dst[k*PW +: PW]       = d;
    wr_src1_id[k*PW +: PW]   = s1;
    wr_src2_id[k*PW +: PW]   = s2;
    wr_src1_rdy[k]           = r1;
    wr_src2_rdy[k]           = r2;
    wr_payload[k*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_wake(input int w, input logic [PW-1:0] id);
    wake_valid[w]        = 1'b1;
    wake_id[w*PW +: PW]  = id;
  endtask

  // One clock: compare outputs to the model at the falling edge, then advance the model.
  task automatic step(input string tag);
    int            rl[$];
    int            n;
    bit            isd[QL];
    ent_t          nq[$];
    ent_t          e;
    bit            wrr;
    logic          lv;
    logic [PW-1:0] ed;
    logic [DW-1:0] ep;
    @(negedge clk);
    wrr = ((QL - mq.size()) >= WN);
    chk("count", DW'(count), DW'(mq.size()));
    chk("wr_ready", DW'(wr_ready), DW'(wrr));
    foreach (isd[i]) isd[i] = 1'b0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) rl.push_back(i);
    n = 0;
    for (int k = 0; k < IN; k++) begin
      lv = 1'b0;
      ed = '0;
      ep = '0;
      if (fu_ready[k] && (n < rl.size())) begin
        lv = 1'b1;
        ed = mq[rl[n]].dst;
        ep = mq[rl[n]].pl;
        isd[rl[n]] = 1'b1;
        n++;
      end
      chk($sformatf("iss_valid%0d", k), DW'(iss_valid[k]), DW'(lv));
      chk($sformatf("iss_dst%0d", k), DW'(iss_dst[k*PW +: PW]), DW'(ed));
      chk($sformatf("iss_payload%0d", k), iss_payload[k*DW +: DW], ep);
    end
    if (!(reset || flush)) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!isd[i]) begin
          e = mq[i];
          e.r1 = e.r1 | woken(e.s1);
          e.r2 = e.r2 | woken(e.s2);
          nq.push_back(e);
        end
      end
      if (wrr) begin
        for (int k = 0; k < WN; k++) begin
          if (wr_valid[k]) begin
            e.dst = wr_dst[k*PW +: PW];
            e.s1  = wr_src1_id[k*PW +: PW];
            e.s2  = wr_src2_id[k*PW +: PW];
            e.r1  = wr_src1_rdy[k] | woken(e.s1);
            e.r2  = wr_src2_rdy[k] | woken(e.s2);
            e.pl  = wr_payload[k*DW +: DW];
            nq.push_back(e);
          end
        end
      end
    end
    $display("cyc %0d %s cnt=%0d wr_ready=%b wr_valid=%b iss_valid=%b dst0=%0d dst1=%0d",
             cyc, tag, count, wr_ready, wr_valid, iss_valid, iss_dst[PW-1:0], iss_dst[2*PW-1:PW]);
    @(posedge clk);
    mq = nq;
    cyc++;
    #1;
  endtask

  initial begin
    int r;
    idle(2'b00);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();

    // Reset state and a pair of immediately-ready ops.
    idle(2'b11);
    #1;
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_wr_ready", DW'(wr_ready), DW'(1));
    chk("rst_iss_valid", DW'(iss_valid), DW'(0));
    step("idle");
    set_wr(0, 6'd5, 6'd1, 1'b1, 6'd2, 1'b1);
    set_wr(1, 6'd6, 6'd3, 1'b1, 6'd4, 1'b1);
    step("wr56");
    idle(2'b11);
    #1;
    chk("tp1_iss_valid", DW'(iss_valid), DW'(2'b11));
    chk("tp1_dst0", DW'(iss_dst[PW-1:0]), DW'(5));
    chk("tp1_dst1", DW'(iss_dst[2*PW-1:PW]), DW'(6));
    step("iss56");
    chk("tp1_drained", DW'(count), DW'(0));

    // Dependency on tag 12 released by a wakeup.
    set_wr(0, 6'd7, 6'd12, 1'b0, 6'd0, 1'b0);
    step("wrdep");
    idle(2'b11);
    step("wait");
    set_wake(2, 6'd12);
    #1;
    chk("dep_not_yet", DW'(iss_valid[0]), DW'(0));
    step("wake12");
    idle(2'b11);
    #1;
    chk("dep_issue", DW'(iss_valid[0]), DW'(1));
    chk("dep_dst", DW'(iss_dst[PW-1:0]), DW'(7));
    step("issdep");

    // Age order with only lane 0 enabled.
    idle(2'b00);
    set_wr(0, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 6'd2, 6'd0, 1'b1, 6'd0, 1'b1);
    step("wr12");
    set_wr(0, 6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 6'd4, 6'd0, 1'b1, 6'd0, 1'b1);
    step("wr34");
    for (int d = 1; d <= 4; d++) begin
      idle(2'b01);
      #1;
      chk("age_dst0", DW'(iss_dst[PW-1:0]), DW'(d));
      chk("age_lane1_idle", DW'(iss_valid[1]), DW'(0));
      step("age");
    end

    // Fill to full with unready ops, then backpressure and release.
    for (int p = 0; p < 4; p++) begin
      idle(2'b11);
      set_wr(0, PW'(10 + 2*p), PW'(30 + p), 1'b0, 6'd0, 1'b0);
      set_wr(1, PW'(11 + 2*p), PW'(30 + p), 1'b0, 6'd0, 1'b0);
      step("fill");
    end
    idle(2'b11);
    set_wr(0, 6'd40, 6'd34, 1'b0, 6'd0, 1'b1);
    set_wr(1, 6'd41, 6'd34, 1'b0, 6'd0, 1'b1);
    #1;
    chk("full_count", DW'(count), DW'(8));
    chk("full_wr_ready", DW'(wr_ready), DW'(0));
    step("hold");
    set_wake(1, 6'd30);
    step("wake30");
    wake_valid = '0;
    #1;
    chk("full_iss2", DW'(iss_valid), DW'(2'b11));
    chk("full_still_blocked", DW'(wr_ready), DW'(0));
    step("iss2");
    chk("full_freed", DW'(wr_ready), DW'(1));
    step("accept");
    idle(2'b11);
    set_wake(0, 6'd31);
    set_wake(1, 6'd32);
    set_wake(2, 6'd33);
    set_wake(3, 6'd34);
    step("wakeall");
    idle(2'b11);
    repeat (4) step("drain");

    // Same-cycle wakeup snooped at dispatch.
    set_wr(0, 6'd9, 6'd0, 1'b1, 6'd20, 1'b0);
    set_wake(3, 6'd20);
    step("snoop");
    idle(2'b11);
    #1;
    chk("snoop_issue", DW'(iss_valid[0]), DW'(1));
    chk("snoop_dst", DW'(iss_dst[PW-1:0]), DW'(9));
    step("issnoop");

    // Flush with a concurrent write.
    for (int p = 0; p < 3; p++) begin
      idle(2'b11);
      set_wr(0, PW'(50 + p), 6'd44, 1'b0, 6'd0, 1'b1);
      if (p < 2) set_wr(1, PW'(53 + p), 6'd44, 1'b0, 6'd0, 1'b1);
      step("fill5");
    end
    idle(2'b11);
    set_wr(0, 6'd60, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 6'd61, 6'd0, 1'b1, 6'd0, 1'b1);
    flush = 1'b1;
    step("flush");
    idle(2'b11);
    #1;
    chk("flush_count", DW'(count), DW'(0));
    chk("flush_iss_valid", DW'(iss_valid), DW'(0));
    chk("flush_wr_ready", DW'(wr_ready), DW'(1));
    step("postflush");

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      idle(IN'($urandom));
      r = $urandom_range(0, 2);
      for (int k = 0; k < WN; k++) begin
        if (k < r)
          set_wr(k, PW'($urandom), PW'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                 PW'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      end
      for (int w = 0; w < KN; w++)
        if ($urandom_range(0, 3) == 0) set_wake(w, PW'($urandom_range(0, 15)));
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Scheduler/controller for the ALU issue queue; sits between rename/dispatch and the ALU execute lanes.
- Holds up to QUEUE_LEN dispatched micro-ops in a collapsing, age-ordered buffer. Slot 0 holds the oldest entry.
- Tracks source-operand readiness from wakeup broadcasts.
- Each cycle, picks the oldest ready entries for ISSUE_NUM ALU lanes and compacts the queue.

Parameters:
- QUEUE_LEN, 8, number of entries (power of two, ≥4).
- WRITE_NUM, 2, dispatch write lanes per cycle (equals MACHINE_WIDTH).
- ISSUE_NUM, 2, ALU issue lanes per cycle.
- WAKE_NUM, 4, wakeup broadcast ports (FU results + ALU bypass + load).
- PREG_W, 6, physical register tag width.
- PAYLOAD_W, 128, opaque bits per entry (ctl, imm, pcplus8, op, exception, src data), stored and returned unmodified.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (mispredict/exception); empties queue
- wr_valid  in  WRITE_NUM  per-lane dispatch request; lanes packed low (lane k valid implies lanes <k valid)
- wr_dst  in  WRITE_NUM*PREG_W  destination tags
- wr_src1_id, wr_src2_id  in  WRITE_NUM*PREG_W  source tags
- wr_src1_rdy, wr_src2_rdy  in  WRITE_NUM  source already available at dispatch
- wr_payload  in  WRITE_NUM*PAYLOAD_W  opaque entry body
- wr_ready  out  1  queue accepts all valid lanes this cycle
- wake_valid  in  WAKE_NUM  wakeup broadcast valid
- wake_id  in  WAKE_NUM*PREG_W  woken physical tag
- fu_ready  in  ISSUE_NUM  ALU lane k can accept an op this cycle
- iss_valid  out  ISSUE_NUM  lane k carries a selected op
- iss_dst  out  ISSUE_NUM*PREG_W  selected destination tag
- iss_payload  out  ISSUE_NUM*PAYLOAD_W  selected payload
- count  out  $clog2(QUEUE_LEN)+1  occupied entries

Behaviour:
- Reset (sync, active-high): all entry valid bits and count cleared, so iss_valid=0 and count=0; wr_ready=1 on the first cycle after reset. Reset overrides every other input in that cycle.
- Entry state: valid, dst, src1/src2 {id, rdy}, payload. Tag 0 is always treated as ready.
- wr_ready = (QUEUE_LEN − count ≥ WRITE_NUM). It is computed from registered count only and is independent of same-cycle issue (conservative).
- Write handshake:
  - Lanes are accepted when wr_ready=1.
  - If wr_valid≠0 and wr_ready=0, nothing is written and dispatch must hold.
  - Accepted lane k lands in slot (count − issued_this_cycle + k), i.e. behind all surviving entries.
- Dispatch snoop: a written source's rdy is set if wr_srcN_rdy=1, or the tag is 0, or it matches any valid wake_id in the same cycle.
- Wakeup:
  - Every valid entry source whose id matches any valid wake_id sets rdy=1 at the clock edge.
  - The woken entry is selectable in the next cycle (one-cycle wakeup-to-select).
  - Duplicate or unmatched wakeups are harmless.
- Select (combinational from registered state):
  - ready(i) = valid & src1.rdy & src2.rdy.
  - Lane 0 takes the lowest-index ready entry if fu_ready[0].
  - Lane 1 takes the next lowest ready entry if fu_ready[1]. If fu_ready[0]=0, lane 1 takes the lowest.
  - Unselected lanes drive iss_valid=0 and zero dst/payload.
  - Issue is fire-and-forget: iss_valid with fu_ready high means consumed.
- Compaction: at the edge, issued slots are removed and surviving entries shift down preserving age order; new writes are then appended. Net count = count − issued + written.
- Simultaneous events:
  - Issue, write and wakeup in the same cycle are all honoured.
  - Wakeups apply to surviving entries after their shift.
  - An entry issued this cycle ignores wakeups.
- Flush: at the edge, all entries are invalidated and count=0. Same-cycle writes are discarded and iss_valid remains asserted combinationally that cycle (execute squashes). Flush takes precedence over write and wakeup.
- Full: count=QUEUE_LEN gives wr_ready=0. Select still operates; free space appears the cycle after issue.
- Empty: iss_valid=0 regardless of fu_ready.
- count never exceeds QUEUE_LEN. Writing when wr_ready=0 is guarded internally (no state change).

Test Plan:
- Reset then idle: count=0, iss_valid=00, wr_ready=1. Write 2 ops with all sources ready (tags 5,6) → next cycle iss_valid=11, lane0 dst=5, lane1 dst=6; following cycle count=0.
- Dependency: write op A src1=12 not ready. Wake tag 12 in cycle T → iss_valid[0]=0 in T, =1 in T+1 with A's dst.
- Age order: fill 4 entries (dst 1..4) all ready, fu_ready=01 → dst1 then dst2, dst3, dst4 on successive cycles on lane0; iss_valid[1] stays 0.
- Full/backpressure: fill to 8 with unready sources → count=8, wr_ready=0. A held wr_valid=11 is not written. Wake one tag readying two entries → issue 2, and wr_ready=1 the next cycle.
- Dispatch snoop: write op with src2=20 not ready while wake_id=20 in the same cycle → op issues the next cycle.
- Flush mid-operation: 5 entries plus a concurrent write of 2 with flush=1 → next cycle count=0, iss_valid=00, wr_ready=1.
